// File: rtl/ld_st_seq.sv
// Load/store sequencer: captures one LSU op, drives DTLB translation, issues the
// dcache request under ready/valid and retires on store drain, load response, fault or watchdog.
module ld_st_seq #(
    parameter int unsigned ST_DRAIN_CYC = 4,
    parameter int unsigned TRNS_TIMEOUT = 16,
    parameter int unsigned LD_TIMEOUT   = 64,
    parameter int unsigned TAG_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_store_i,
    input  logic             is_load_i,
    input  logic [TAG_W-1:0] op_tag_i,
    input  logic             kill_mem_op_i,
    input  logic             dtlb_hit_i,
    input  logic             dtlb_fault_i,
    input  logic             mem_req_rdy_i,
    input  logic             ld_resp_valid_i,
    input  logic [TAG_W-1:0] ld_resp_tag_i,
    output logic             trns_req_o,
    output logic             trns_ena_o,
    output logic             mem_req_valid_o,
    output logic             mem_req_is_st_o,
    output logic [TAG_W-1:0] mem_req_tag_o,
    output logic             str_rdy_o,
    output logic             dmem_lock_o,
    output logic             done_o,
    output logic             fault_o,
    output logic             timeout_o
);

    localparam int unsigned CNT_W  = $clog2(ST_DRAIN_CYC + 1);
    localparam int unsigned WDOG_W = 16;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRNS      = 3'd1;
    localparam logic [2:0] S_TRNS_WAIT = 3'd2;
    localparam logic [2:0] S_MEM_REQ   = 3'd3;
    localparam logic [2:0] S_ST_DRAIN  = 3'd4;
    localparam logic [2:0] S_WAIT_LD   = 3'd5;
    localparam logic [2:0] S_DRAIN_LD  = 3'd6;
    localparam logic [2:0] S_FAULT     = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_st_q, is_st_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              done_d, timeout_d;
    logic              trns_req_q, trns_ena_q, valid_q, str_rdy_q, lock_q;
    logic              done_q, fault_q, timeout_q;
    logic              resp_match;
    logic              trns_expired, ld_expired;

    assign resp_match   = ld_resp_valid_i && (ld_resp_tag_i == tag_q);
    assign trns_expired = (wdog_q == WDOG_W'(TRNS_TIMEOUT - 1));
    assign ld_expired   = (wdog_q == WDOG_W'(LD_TIMEOUT - 1));

    // Next-state, capture and retirement decisions.
    always_comb begin
        state_d   = state_q;
        is_st_d   = is_st_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        wdog_d    = wdog_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!kill_mem_op_i && (is_store_i || is_load_i)) begin
                    is_st_d = is_store_i;
                    tag_d   = op_tag_i;
                    state_d = S_TRNS;
                end
            end
            S_TRNS:      state_d = kill_mem_op_i ? S_IDLE : S_TRNS_WAIT;
            S_TRNS_WAIT: begin
                if (kill_mem_op_i)     state_d = S_IDLE;
                else if (dtlb_fault_i) state_d = S_FAULT;
                else if (dtlb_hit_i)   state_d = S_MEM_REQ;
                else if (trns_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_MEM_REQ: begin
                // A completed handshake commits the op even if kill arrives with it.
                if (mem_req_rdy_i)      state_d = is_st_q ? S_ST_DRAIN : S_WAIT_LD;
                else if (kill_mem_op_i) state_d = S_IDLE;
            end
            S_ST_DRAIN: begin
                if (cnt_q == CNT_W'(ST_DRAIN_CYC - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_LD: begin
                if (resp_match) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (ld_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (kill_mem_op_i) begin
                    state_d = S_DRAIN_LD;
                end
            end
            S_DRAIN_LD: begin
                if (resp_match) begin
                    state_d = S_IDLE;
                end else if (ld_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_FAULT:     state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        // Watchdog and drain counter restart on every state entry.
        if (state_d != state_q) begin
            wdog_d = '0;
            cnt_d  = '0;
        end else if (!(&wdog_q)) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wdog_q     <= '0;
            cnt_q      <= '0;
            is_st_q    <= 1'b0;
            tag_q      <= '0;
            trns_req_q <= 1'b0;
            trns_ena_q <= 1'b0;
            valid_q    <= 1'b0;
            str_rdy_q  <= 1'b0;
            lock_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            cnt_q      <= cnt_d;
            is_st_q    <= is_st_d;
            tag_q      <= tag_d;
            trns_req_q <= (state_d == S_TRNS);
            trns_ena_q <= (state_d == S_TRNS) || (state_d == S_TRNS_WAIT);
            valid_q    <= (state_d == S_MEM_REQ);
            str_rdy_q  <= (state_d == S_ST_DRAIN);
            lock_q     <= (state_d != S_IDLE);
            done_q     <= done_d;
            fault_q    <= (state_d == S_FAULT);
            timeout_q  <= timeout_d;
        end
    end

    assign trns_req_o      = trns_req_q;
    assign trns_ena_o      = trns_ena_q;
    assign mem_req_valid_o = valid_q;
    assign mem_req_is_st_o = is_st_q;
    assign mem_req_tag_o   = tag_q;
    assign str_rdy_o       = str_rdy_q;
    assign dmem_lock_o     = lock_q;
    assign done_o          = done_q;
    assign fault_o         = fault_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_ld_st_seq.sv
// Directed bench for ld_st_seq; retirement pulses are checked against a queue of expected outcomes.
module tb_ld_st_seq;

    localparam logic [2:0] RET_DONE  = 3'b100;
    localparam logic [2:0] RET_FAULT = 3'b010;
    localparam logic [2:0] RET_TO    = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       is_store_i = 1'b0, is_load_i = 1'b0;
    logic [2:0] op_tag_i = '0;
    logic       kill_mem_op_i = 1'b0, dtlb_hit_i = 1'b0, dtlb_fault_i = 1'b0;
    logic       mem_req_rdy_i = 1'b0, ld_resp_valid_i = 1'b0;
    logic [2:0] ld_resp_tag_i = '0;
    logic       trns_req_o, trns_ena_o, mem_req_valid_o, mem_req_is_st_o;
    logic [2:0] mem_req_tag_o;
    logic       str_rdy_o, dmem_lock_o, done_o, fault_o, timeout_o;

    ld_st_seq #(.ST_DRAIN_CYC(4), .TRNS_TIMEOUT(16), .LD_TIMEOUT(64), .TAG_W(3)) dut (
        .clk(clk), .rst(rst),
        .is_store_i(is_store_i), .is_load_i(is_load_i), .op_tag_i(op_tag_i),
        .kill_mem_op_i(kill_mem_op_i), .dtlb_hit_i(dtlb_hit_i), .dtlb_fault_i(dtlb_fault_i),
        .mem_req_rdy_i(mem_req_rdy_i), .ld_resp_valid_i(ld_resp_valid_i),
        .ld_resp_tag_i(ld_resp_tag_i),
        .trns_req_o(trns_req_o), .trns_ena_o(trns_ena_o), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_is_st_o(mem_req_is_st_o), .mem_req_tag_o(mem_req_tag_o),
        .str_rdy_o(str_rdy_o), .dmem_lock_o(dmem_lock_o), .done_o(done_o),
        .fault_o(fault_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int n_valid, n_trnsreq, n_strrdy, n;
    logic [2:0] exp_q[$];

    function automatic logic [12:0] outs();
        return {trns_req_o, trns_ena_o, mem_req_valid_o, mem_req_is_st_o, mem_req_tag_o,
                str_rdy_o, dmem_lock_o, done_o, fault_o, timeout_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock, sample just after the edge and score any retirement pulse.
    task automatic step();
        logic [2:0] e;
        @(posedge clk);
        #1;
        n_valid   += int'(mem_req_valid_o);
        n_trnsreq += int'(trns_req_o);
        n_strrdy  += int'(str_rdy_o);
        if (done_o || fault_o || timeout_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire", {29'd0, done_o, fault_o, timeout_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("retire_kind", {29'd0, done_o, fault_o, timeout_o}, {29'd0, e});
            end
        end
    endtask

    task automatic clr();
        n_valid = 0; n_trnsreq = 0; n_strrdy = 0;
    endtask

    task automatic start_op(input logic st, input logic [2:0] tag);
        clr();
        is_store_i = st; is_load_i = !st; op_tag_i = tag;
        step();
        is_store_i = 1'b0; is_load_i = 1'b0; op_tag_i = '0;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (1) begin
            step();
            cyc++;
            if (!dmem_lock_o) break;
            if (cyc >= budget) begin
                chk({tag, "_bound"}, dmem_lock_o, 1'b0);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        clr();
        step(); step();
        chk("reset_outs", outs(), 13'd0);
        rst = 1'b1;
        step();
        chk("idle_outs", outs(), 13'd0);

        // Store: hit after two TRNS_WAIT cycles, ready immediately.
        start_op(1'b1, 3'd2);
        chk("t1_trns", {trns_req_o, trns_ena_o, dmem_lock_o}, 3'b111);
        step();
        chk("t1_twait", {trns_req_o, trns_ena_o}, 2'b01);
        step();
        dtlb_hit_i = 1'b1; step(); dtlb_hit_i = 1'b0;
        chk("t1_memreq", {mem_req_valid_o, mem_req_is_st_o, mem_req_tag_o}, 5'b11010);
        mem_req_rdy_i = 1'b1; exp_q.push_back(RET_DONE);
        step(); mem_req_rdy_i = 1'b0;
        chk("t1_drain_start", {mem_req_valid_o, str_rdy_o}, 2'b01);
        wait_idle("t1", 20, n);
        chk("t1_done_at_unlock", done_o, 1);
        chk("t1_strrdy_cycles", n_strrdy, 4);
        chk("t1_valid_cycles", n_valid, 1);
        chk("t1_trnsreq_cycles", n_trnsreq, 1);
        chk("t1_sb_empty", exp_q.size(), 0);
        step();
        chk("t1_done_one_cycle", done_o, 0);

        // Load tag 5 with three cycles of backpressure; wrong-tag response ignored.
        start_op(1'b0, 3'd5);
        step();
        dtlb_hit_i = 1'b1; step(); dtlb_hit_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold", {mem_req_valid_o, mem_req_is_st_o, mem_req_tag_o}, 5'b10101);
            step();
        end
        chk("t2_hold_last", {mem_req_valid_o, mem_req_tag_o}, 4'b1101);
        mem_req_rdy_i = 1'b1; step(); mem_req_rdy_i = 1'b0;
        chk("t2_valid_cycles", n_valid, 4);
        chk("t2_waitld", {mem_req_valid_o, dmem_lock_o}, 2'b01);
        ld_resp_valid_i = 1'b1; ld_resp_tag_i = 3'd2;
        step();
        chk("t2_mismatch_ignored", {dmem_lock_o, done_o}, 2'b10);
        ld_resp_tag_i = 3'd5; exp_q.push_back(RET_DONE);
        step(); ld_resp_valid_i = 1'b0;
        chk("t2_done", {dmem_lock_o, done_o}, 2'b01);
        chk("t2_sb_empty", exp_q.size(), 0);

        // Fault and hit together: fault wins, no cache request.
        start_op(1'b0, 3'd1);
        step();
        dtlb_fault_i = 1'b1; dtlb_hit_i = 1'b1; exp_q.push_back(RET_FAULT);
        step(); dtlb_fault_i = 1'b0; dtlb_hit_i = 1'b0;
        chk("t3_fault", {fault_o, dmem_lock_o, mem_req_valid_o}, 3'b110);
        step();
        chk("t3_idle", {fault_o, dmem_lock_o}, 2'b00);
        chk("t3_no_valid", n_valid, 0);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Translation watchdog.
        start_op(1'b1, 3'd0);
        step();
        exp_q.push_back(RET_TO);
        wait_idle("t4", 40, n);
        chk("t4_cycles", n, 16);
        chk("t4_timeout", timeout_o, 1);
        chk("t4_sb_empty", exp_q.size(), 0);

        // Load-response watchdog.
        start_op(1'b0, 3'd4);
        step();
        dtlb_hit_i = 1'b1; step(); dtlb_hit_i = 1'b0;
        mem_req_rdy_i = 1'b1; step(); mem_req_rdy_i = 1'b0;
        exp_q.push_back(RET_TO);
        wait_idle("t5", 100, n);
        chk("t5_cycles", n, 64);
        chk("t5_timeout", timeout_o, 1);
        chk("t5_sb_empty", exp_q.size(), 0);

        // Kill in WAIT_LD: lock held until the matching response drains, no done.
        start_op(1'b0, 3'd3);
        step();
        dtlb_hit_i = 1'b1; step(); dtlb_hit_i = 1'b0;
        mem_req_rdy_i = 1'b1; step(); mem_req_rdy_i = 1'b0;
        kill_mem_op_i = 1'b1; step(); kill_mem_op_i = 1'b0;
        chk("t6_lock_after_kill", dmem_lock_o, 1);
        step(); step();
        chk("t6_lock_held", dmem_lock_o, 1);
        ld_resp_valid_i = 1'b1; ld_resp_tag_i = 3'd3;
        step(); ld_resp_valid_i = 1'b0;
        chk("t6_drained", {dmem_lock_o, done_o}, 2'b00);

        // Reset during ST_DRAIN, then a load straight after release.
        start_op(1'b1, 3'd7);
        step();
        dtlb_hit_i = 1'b1; step(); dtlb_hit_i = 1'b0;
        mem_req_rdy_i = 1'b1; step(); mem_req_rdy_i = 1'b0;
        step();
        chk("t7_in_drain", str_rdy_o, 1);
        rst = 1'b0;
        step();
        chk("t7_reset_outs", outs(), 13'd0);
        rst = 1'b1;
        start_op(1'b0, 3'd6);
        chk("t7_new_trns", {trns_req_o, dmem_lock_o, mem_req_tag_o}, 5'b11110);
        step();
        dtlb_hit_i = 1'b1; step(); dtlb_hit_i = 1'b0;
        mem_req_rdy_i = 1'b1; step(); mem_req_rdy_i = 1'b0;
        ld_resp_valid_i = 1'b1; ld_resp_tag_i = 3'd6; exp_q.push_back(RET_DONE);
        step(); ld_resp_valid_i = 1'b0;
        chk("t7_done", {dmem_lock_o, done_o}, 2'b01);
        chk("t7_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
